// File: rtl/booth_pkg.sv
// Shared types and sizing for the radix-8 Booth multiplier datapath.
package booth_pkg;

  localparam int unsigned N      = 23;
  localparam int unsigned NUM_PP = 9;
  localparam int unsigned PP_W   = N + 3;
  localparam int unsigned PROD_W = 2 * N + 2;
  localparam int unsigned ACC_W  = 3 * (NUM_PP - 1) + N + 6;
  localparam int unsigned ROW_W  = $clog2(NUM_PP + 1);

  // Booth select output: magnitude or its ones' complement, plus deferred +1.
  typedef struct packed {
    logic [PP_W-1:0] pp;
    logic            sign;
  } t_bs_comp_out;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } t_acc_state;

endpackage

// File: rtl/booth_pp_row_extend.sv
// Turns one Booth row into its weighted accumulator term:
// sign-extend, apply the deferred +sign correction, shift by 3*row.
module booth_pp_row_extend
  import booth_pkg::*;
(
  input  t_bs_comp_out     pp_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [ACC_W-1:0] term_o
);

  localparam int unsigned SH_W = ROW_W + 2;

  logic [ACC_W-1:0] ext_c;
  logic [SH_W-1:0]  shamt_c;

  always_comb begin
    ext_c   = {{(ACC_W - PP_W - 1){pp_i.sign}}, pp_i.sign, pp_i.pp} + ACC_W'(pp_i.sign);
    shamt_c = SH_W'(row_i) + SH_W'({row_i, 1'b0});
    term_o  = ext_c << shamt_c;
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates NUM_PP Booth rows per multiply and hands the unsigned
// mantissa product to the normalisation stage with a valid/ready handshake.
module booth_pp_accumulator
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_pp_valid,
  output logic              o_pp_ready,
  input  t_bs_comp_out      i_pp,
  output logic              o_prod_valid,
  input  logic              i_prod_ready,
  output logic [PROD_W-1:0] o_prod,
  output logic [ROW_W-1:0]  o_row_cnt
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_PP - 1);

  t_acc_state        state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  term_c;
  logic [ROW_W-1:0]  row_cnt_q;
  logic              pp_ready_q;
  logic              prod_valid_q;
  logic [PROD_W-1:0] prod_q;

  booth_pp_row_extend u_row_extend (
    .pp_i   (i_pp),
    .row_i  (row_cnt_q),
    .term_o (term_c)
  );

  // Upper bits above PROD_W wrap silently; legal Booth rows never reach them.
  always_comb acc_d = acc_q + term_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC;
      acc_q        <= '0;
      row_cnt_q    <= '0;
      pp_ready_q   <= 1'b1;
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
    end else if (i_flush) begin
      state_q      <= ACC;
      acc_q        <= '0;
      row_cnt_q    <= '0;
      pp_ready_q   <= 1'b1;
      prod_valid_q <= 1'b0;
    end else if (state_q == ACC) begin
      if (i_pp_valid && pp_ready_q) begin
        acc_q     <= acc_d;
        row_cnt_q <= row_cnt_q + ROW_W'(1);
        if (row_cnt_q == LAST_ROW) begin
          state_q      <= OUT;
          pp_ready_q   <= 1'b0;
          prod_valid_q <= 1'b1;
          prod_q       <= acc_d[PROD_W-1:0];
        end
      end
    end else begin
      if (i_prod_ready) begin
        state_q      <= ACC;
        acc_q        <= '0;
        row_cnt_q    <= '0;
        pp_ready_q   <= 1'b1;
        prod_valid_q <= 1'b0;
      end
    end
  end

  assign o_pp_ready   = pp_ready_q;
  assign o_prod_valid = prod_valid_q;
  assign o_prod       = prod_q;
  assign o_row_cnt    = row_cnt_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench: arithmetic reference model compared every cycle,
// plus directed multiplies with hand-computed products.
module tb_booth_pp_accumulator;
  import booth_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              i_flush;
  logic              i_pp_valid;
  logic              o_pp_ready;
  t_bs_comp_out      i_pp;
  logic              o_prod_valid;
  logic              i_prod_ready;
  logic [PROD_W-1:0] o_prod;
  logic [ROW_W-1:0]  o_row_cnt;

  booth_pp_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_pp_valid   (i_pp_valid),
    .o_pp_ready   (o_pp_ready),
    .i_pp         (i_pp),
    .o_prod_valid (o_prod_valid),
    .i_prod_ready (i_prod_ready),
    .o_prod       (o_prod),
    .o_row_cnt    (o_row_cnt)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  bit rand_ready_en = 1'b0;
  bit ready_force = 1'b0;
  t_bs_comp_out cur_rows [NUM_PP];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Numeric value of a row: two's complement of {s, pp} plus s.
  function automatic logic signed [63:0] row_val(input t_bs_comp_out w);
    logic signed [63:0] v;
    v = {{37{w.sign}}, w.sign, w.pp};
    return v + 64'(w.sign);
  endfunction

  // Radix-8 Booth recoding of an unsigned 24-bit multiplier.
  task automatic booth_rows(input logic [N:0] x, input logic [N:0] y);
    logic [27:0] ye;
    logic [27:0] mag;
    int d;
    ye = {3'b000, y, 1'b0};
    for (int i = 0; i < int'(NUM_PP); i++) begin
      d = -4 * int'(ye[3*i+3]) + 2 * int'(ye[3*i+2]) + int'(ye[3*i+1]) + int'(ye[3*i]);
      mag = 28'(x) * 28'((d < 0) ? -d : d);
      cur_rows[i].pp   = (d < 0) ? ~mag[PP_W-1:0] : mag[PP_W-1:0];
      cur_rows[i].sign = (d < 0);
    end
  endtask

  task automatic simple_rows(input t_bs_comp_out r0, input t_bs_comp_out r1);
    for (int i = 0; i < int'(NUM_PP); i++) cur_rows[i] = '0;
    cur_rows[0] = r0;
    cur_rows[1] = r1;
  endtask

  // Reference model: cycle-level transaction view with plain arithmetic sums.
  logic               m_out = 1'b0;
  int                 m_cnt = 0;
  logic signed [63:0] m_sum = '0;
  logic [63:0]        m_prod = '0;
  logic signed [63:0] nsum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 1'b0; m_cnt <= 0; m_sum <= '0;
    end else if (i_flush) begin
      m_out <= 1'b0; m_cnt <= 0; m_sum <= '0;
    end else if (m_out) begin
      if (i_prod_ready) begin
        m_out <= 1'b0; m_cnt <= 0; m_sum <= '0;
      end
    end else if (i_pp_valid) begin
      nsum = m_sum + (row_val(i_pp) <<< (3 * m_cnt));
      m_sum <= nsum;
      m_cnt <= m_cnt + 1;
      if (m_cnt == int'(NUM_PP) - 1) begin
        m_out  <= 1'b1;
        m_prod <= {16'h0, nsum[PROD_W-1:0]};
      end
    end
  end

  always @(negedge clk) begin
    i_prod_ready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_force;
    if (cmp_en) begin
      chk("cyc_pp_ready", 64'(o_pp_ready), 64'(!m_out));
      chk("cyc_prod_valid", 64'(o_prod_valid), 64'(m_out));
      chk("cyc_row_cnt", 64'(o_row_cnt), 64'(m_cnt));
      if (m_out) chk("cyc_prod", 64'(o_prod), m_prod);
    end
  end

  // Present rows first..last; each returns #1 after its handshake edge.
  task automatic send_rows(input int first, input int last, input bit gaps);
    bit rdy;
    int n;
    for (int i = first; i <= last; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        i_pp_valid = 1'b0;
        i_pp = t_bs_comp_out'($urandom);
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      i_pp_valid = 1'b1;
      i_pp = cur_rows[i];
      n = 0;
      do begin
        rdy = o_pp_ready;
        @(posedge clk); #1;
        n++;
      end while (!rdy && n < 60);
      if (!rdy) chk("row_handshake_timeout", 64'(rdy), 64'd1);
    end
  endtask

  task automatic end_mult(input string name, input logic [47:0] exp, input bit use_exp);
    i_pp_valid = 1'b0;
    chk({name, "_latency"}, 64'(o_prod_valid), 64'd1);
    if (use_exp) chk(name, 64'(o_prod), 64'(exp));
  endtask

  task automatic consume();
    ready_force = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b0;
    chk("consume_valid_low", 64'(o_prod_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_pp_ready"}, 64'(o_pp_ready), 64'd1);
    chk({name, "_prod_valid"}, 64'(o_prod_valid), 64'd0);
    chk({name, "_prod"}, 64'(o_prod), 64'd0);
    chk({name, "_row_cnt"}, 64'(o_row_cnt), 64'd0);
  endtask

  initial begin
    t_bs_comp_out r0, r1, p5;
    logic [N:0] x, y;
    logic [47:0] held;
    bit legal;

    rst_n = 1'b1; i_flush = 1'b0; i_pp_valid = 1'b0; i_pp = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Single positive row
    p5.pp = PP_W'(5); p5.sign = 1'b0;
    r1 = '0;
    simple_rows(p5, r1);
    send_rows(0, 8, 1'b0);
    end_mult("positive_row", 48'd5, 1'b1);
    consume();

    // Deferred correction: -5 + 8
    r0.pp = ~PP_W'(5); r0.sign = 1'b1;
    r1.pp = PP_W'(1);  r1.sign = 1'b0;
    simple_rows(r0, r1);
    send_rows(0, 8, 1'b0);
    end_mult("correction", 48'd3, 1'b1);
    consume();

    booth_rows(24'h800000, 24'h800000);
    send_rows(0, 8, 1'b0);
    end_mult("full_800000", 48'h400000000000, 1'b1);
    consume();

    // Backpressure with next row 0 already waiting
    booth_rows(24'hFFFFFF, 24'hFFFFFF);
    send_rows(0, 8, 1'b0);
    end_mult("full_ffffff", 48'hFFFFFE000001, 1'b1);
    held = o_prod;
    i_pp_valid = 1'b1; i_pp = p5;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_pp_ready", 64'(o_pp_ready), 64'd0);
      chk("bp_prod_stable", 64'(o_prod), 64'(held));
      chk("bp_row_cnt", 64'(o_row_cnt), 64'(NUM_PP));
    end
    ready_force = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b0;
    chk("bp_after_hs_valid", 64'(o_prod_valid), 64'd0);
    chk("bp_after_hs_row_cnt", 64'(o_row_cnt), 64'd0);
    @(posedge clk); #1;
    chk("bp_row0_accepted", 64'(o_row_cnt), 64'd1);
    r1 = '0;
    simple_rows(p5, r1);
    send_rows(1, 8, 1'b0);
    end_mult("bp_next_mult", 48'd5, 1'b1);
    consume();

    // Flush with row 4 valid
    booth_rows(24'h9ABCDE, 24'hC0FFEE);
    send_rows(0, 3, 1'b0);
    i_pp = cur_rows[4]; i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_pp_valid = 1'b0;
    chk("flush_row_cnt", 64'(o_row_cnt), 64'd0);
    booth_rows(24'hABCDEF, 24'h123456);
    send_rows(0, 8, 1'b0);
    end_mult("after_flush", 48'(48'hABCDEF * 48'h123456), 1'b1);
    // Flush while the product is pending
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_out_valid", 64'(o_prod_valid), 64'd0);
    chk("flush_out_pp_ready", 64'(o_pp_ready), 64'd1);

    // Asynchronous reset mid-multiply
    booth_rows(24'hFFFFFF, 24'h800001);
    send_rows(0, 3, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    i_pp_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    booth_rows(24'h800000, 24'h800000);
    send_rows(0, 8, 1'b0);
    end_mult("after_reset", 48'h400000000000, 1'b1);
    consume();

    // Randomized multiplies with random gaps and downstream stalls
    rand_ready_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      x = 24'($urandom);
      y = 24'($urandom);
      legal = ($urandom_range(0, 4) != 0);
      if (legal) begin
        booth_rows(x, y);
      end else begin
        for (int i = 0; i < int'(NUM_PP); i++) begin
          cur_rows[i].pp = PP_W'($urandom);
          cur_rows[i].sign = 1'($urandom_range(0, 1));
        end
      end
      send_rows(0, 8, 1'b1);
      end_mult("rand_xy", 48'(48'(x) * 48'(y)), legal);
    end
    rand_ready_en = 1'b0;
    ready_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_valid", 64'(o_prod_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Sequential consumer of the radix-8 Booth select partial-product stream.
- Accepts one partial product per handshake, in the `booth_pkg::t_bs_comp_out` format: {pp[N+2:0], sign}.
- For each row it applies the deferred two's-complement correction (+sign), sign-extends, weights by 8^row and accumulates.
- After NUM_PP rows it presents the unsigned (N+1)x(N+1) mantissa product to the normalisation stage.

Parameters:
- N, 23: mantissa width excluding hidden bit. Row pp width is N+3; input word is N+4.
- NUM_PP, 9: partial products per multiply, ceil((N+2)/3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous abort of the current multiply.
- i_pp_valid  in  1  partial product valid.
- o_pp_ready  out  1  accumulator can accept a row.
- i_pp  in  N+4  partial product {pp[N+2:0], sign}, rows in order 0..NUM_PP-1.
- o_prod_valid  out  1  product valid.
- i_prod_ready  in  1  downstream accepts product.
- o_prod  out  2N+2  mantissa product.
- o_row_cnt  out  $clog2(NUM_PP+1)  rows accepted in current multiply.

Behaviour:
- Reset is asynchronous, active-low. All of the following take effect immediately:
  - state=ACC, acc=0, row_cnt=0.
  - o_pp_ready=1, o_prod_valid=0, o_prod=0, o_row_cnt=0.
- Row value: V = two's-complement value of the (N+4)-bit pattern {s, pp[N+2:0]}, plus s.
  - Example: s=1, pp=~M gives -M.
  - Example: s=0, pp=M gives M.
- Accumulator width ACC_W = 3*(NUM_PP-1)+N+6 (53 for defaults).
  - The row is sign-extended to ACC_W, then shifted left by 3*row_cnt.
  - Addition is modulo 2^ACC_W.
- FSM, two states:
  - ACC: o_pp_ready=1, o_prod_valid=0.
    - On i_pp_valid&&o_pp_ready: acc += V<<3*row_cnt, row_cnt++.
    - If this was row NUM_PP-1: go to OUT and register o_prod = (acc+term)[2N+1:0].
  - OUT: o_pp_ready=0, o_prod_valid=1, o_prod held stable.
    - On i_prod_ready: go to ACC, clear acc and row_cnt.
- Latency: o_prod_valid rises the cycle after the last row handshake.
  - Minimum period is NUM_PP+1 cycles per multiply.
  - The next multiply's row 0 may be offered in the cycle after the product handshake.
- Rows offered while in OUT are not accepted (o_pp_ready=0). The upstream must hold i_pp and i_pp_valid until the handshake completes.
- i_flush (synchronous, highest priority):
  - Next state is ACC with acc=0 and row_cnt=0, o_prod_valid=0.
  - A row presented in the same cycle is discarded.
  - Flush in OUT drops the pending product.
- i_pp sampled only on handshake. Values are ignored while i_pp_valid=0.
- Overflow: the final sum is non-negative and < 2^(2N+2) for legal Booth rows.
  - Upper acc bits are discarded without a check.
  - Illegal rows yield the truncated sum.
- o_row_cnt equals row_cnt. It reads NUM_PP while in OUT.

Decomposition:
- Additions to booth_pkg:
  - localparams NUM_PP and PROD_W=2N+2.
  - Enum t_acc_state {ACC, OUT}.
  - Reuse of t_bs_comp_out as the i_pp type.
- Sub-module booth_pp_row_extend (combinational):
  - Input: pp word and row index.
  - Output: ACC_W-bit term (sign-extend, +s, shift 3*row).
  - Unit-testable in isolation.

Test Plan:
- Reset mid-multiply:
  - Stimulus: feed rows 0-3, assert rst_n=0 asynchronously (off clock edge).
  - Response: outputs drop to reset values immediately. A subsequent full 9-row multiply gives the correct product, uncontaminated.
- Positive row:
  - Stimulus: row0={26'd5, 1'b0}, rows1-8=0.
  - Response: o_prod=48'd5, o_prod_valid exactly 1 cycle after row 8.
- Correction term:
  - Stimulus: row0={~26'd5, 1'b1}, row1={26'd1, 1'b0}, rest 0.
  - Response: o_prod=48'd3 (-5+8).
- Full multiply:
  - Stimulus: X=Y=24'h800000, rows from the bench Booth model.
  - Response: o_prod=48'h400000000000.
  - Repeat with X=Y=24'hFFFFFF: o_prod=48'hFFFFFE000001.
- Backpressure:
  - Stimulus: i_prod_ready=0 for 5 cycles after o_prod_valid.
  - Response: o_prod stable, o_pp_ready=0 throughout, row 0 of the next multiply accepted the cycle after the product handshake.
- Flush:
  - Stimulus: i_flush with row 4 valid.
  - Response: row dropped, o_row_cnt=0 next cycle, next multiply correct. Flush in OUT clears o_prod_valid next cycle.
